// File: rtl/sd_spi_master_if.sv
// sd_spi_master_if: host handshake, chip-select and SPI pin bundle for sd_spi_master
interface sd_spi_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy;
  logic       done;
  logic       cs_wr;
  logic       cs_val;
  logic       sd_sck;
  logic       sd_mosi;
  logic       sd_cs_n;
  logic       sd_miso;
  logic       sd_act;
  modport master (
    input  start, tx_data, cs_wr, cs_val, sd_miso,
    output rx_data, busy, done, sd_sck, sd_mosi, sd_cs_n, sd_act
  );
  modport slave (
    output start, tx_data, cs_wr, cs_val, sd_miso,
    input  rx_data, busy, done, sd_sck, sd_mosi, sd_cs_n, sd_act
  );
endinterface

// File: rtl/sd_spi_master.sv
// sd_spi_master: SPI mode-0 byte master for SD cards; optional activity timeout via macro SD_SPI_ACT_EN
module sd_spi_master #(
  parameter int CLK_DIV = 2
) (
  input logic             clk_sys,
  input logic             reset_n,
  sd_spi_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  state_t     r_state, w_state;
  logic [7:0] r_div, w_div;
  logic [7:0] r_sh, w_sh;
  logic [7:0] r_rx, w_rx;
  logic [7:0] r_rxd, w_rxd;
  logic [2:0] r_bit, w_bit;
  logic       r_sck, w_sck;
  logic       r_busy, w_busy;
  logic       r_done, w_done;
  logic       r_cs_n, w_cs_n;
  // Next-state and output logic; the transmit shifter refills with ones so MOSI idles high
  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_sh    = r_sh;
    w_rx    = r_rx;
    w_rxd   = r_rxd;
    w_bit   = r_bit;
    w_sck   = r_sck;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_cs_n  = bus.cs_wr ? bus.cs_val : r_cs_n;
    case (r_state)
      IDLE: if (bus.start && !r_done) begin
        w_state = LOW;
        w_sh    = bus.tx_data;
        w_bit   = 3'd0;
        w_div   = 8'd0;
        w_busy  = 1'b1;
      end
      LOW: if (r_div == DIV_LAST) begin
        w_state = HIGH;
        w_div   = 8'd0;
        w_sck   = 1'b1;
        w_rx    = {r_rx[6:0], bus.sd_miso};
      end else w_div = r_div + 8'd1;
      HIGH: if (r_div == DIV_LAST) begin
        w_div = 8'd0;
        w_sck = 1'b0;
        w_sh  = {r_sh[6:0], 1'b1};
        if (r_bit == 3'd7) begin
          w_state = IDLE;
          w_sh    = 8'hFF;
          w_rxd   = r_rx;
          w_done  = 1'b1;
          w_busy  = 1'b0;
        end else begin
          w_state = LOW;
          w_bit   = r_bit + 3'd1;
        end
      end else w_div = r_div + 8'd1;
      default: w_state = IDLE;
    endcase
  end
  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_div   <= 8'd0;
      r_sh    <= 8'hFF;
      r_rx    <= 8'd0;
      r_rxd   <= 8'd0;
      r_bit   <= 3'd0;
      r_sck   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_sh    <= w_sh;
      r_rx    <= w_rx;
      r_rxd   <= w_rxd;
      r_bit   <= w_bit;
      r_sck   <= w_sck;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cs_n  <= w_cs_n;
    end
  end
  assign bus.rx_data = r_rxd;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sd_sck  = r_sck;
  assign bus.sd_mosi = r_sh[7];
  assign bus.sd_cs_n = r_cs_n;
`ifdef SD_SPI_ACT_EN
  localparam logic [19:0] TO_MAX = 20'd1000000;
  logic [19:0] r_to;
  logic        r_mosi_q, r_miso_q;
  // Idle timeout: restarts on any data-line toggle, saturates at TO_MAX; reset starts it expired
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_to     <= TO_MAX;
      r_mosi_q <= 1'b1;
      r_miso_q <= 1'b1;
    end else begin
      r_mosi_q <= r_sh[7];
      r_miso_q <= bus.sd_miso;
      r_to     <= (r_sh[7] != r_mosi_q || bus.sd_miso != r_miso_q) ? 20'd0 :
                  (r_to == TO_MAX) ? r_to : r_to + 20'd1;
    end
  end
  assign bus.sd_act = r_to < TO_MAX;
`else
  assign bus.sd_act = 1'b0;
`endif
endmodule

// File: doc/sd_spi_master.md
SD_SPI_MASTER -- requirements
Module: sd_spi_master

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2, SCK half-period in clk_sys cycles, legal range 1..255.
REQ-002 SHALL provide port clk_sys  input  1  single clock domain; all logic on its rising edge.
REQ-003 SHALL provide port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  request one 8-bit transfer; sampled only when busy=0.
REQ-005 SHALL provide port tx_data  input  8  byte to transmit; captured on the accepted start cycle.
REQ-006 SHALL provide port rx_data  output  8  byte received by the last completed transfer.
REQ-007 SHALL provide port busy  output  1  high from the cycle after the accepted start until done.
REQ-008 SHALL provide port done  output  1  one-cycle pulse at transfer completion.
REQ-009 SHALL provide port cs_wr  input  1  write strobe for the chip-select register.
REQ-010 SHALL provide port cs_val  input  1  value written to sd_cs_n on cs_wr.
REQ-011 SHALL provide ports sd_sck, sd_mosi and sd_cs_n  output  1 each  SPI clock, data out and chip select (active low).
REQ-012 SHALL provide port sd_miso  input  1  SPI data in.
REQ-013 SHALL provide port sd_act  output  1  activity indicator (see Configuration).

Function
REQ-014 SHALL implement SPI mode 0: SCK idles low, MOSI changes on falling edges, MISO sampled on rising edges, MSB first.
REQ-015 SHALL use the states IDLE, LOW and HIGH, plus a 3-bit bit counter and an 8-bit divider counter.
REQ-016 IDLE + start SHALL load the shift register with tx_data, drive sd_mosi=tx_data[7], clear the bit counter, enter LOW and assert busy the next cycle.
REQ-017 LOW SHALL hold sd_sck=0 for CLK_DIV cycles, then enter HIGH.
REQ-018 On entering HIGH, the block SHALL set sd_sck=1 and shift sd_miso into the LSB of the receive register.
REQ-019 HIGH SHALL last CLK_DIV cycles. On exit with bit counter < 7, the block SHALL increment the counter, drive the next MOSI bit and enter LOW.
REQ-020 On exit from HIGH with bit counter = 7, the block SHALL drop sd_sck to 0, update rx_data, pulse done for one cycle, deassert busy in the same cycle and return to IDLE.
REQ-021 Latency SHALL be exactly 2*8*CLK_DIV+1 cycles, measured from the accepted start cycle to the done cycle.
REQ-022 start while busy=1 SHALL be ignored; no queuing.
REQ-023 start in the same cycle as done SHALL be ignored. start in the cycle after done SHALL be accepted.
REQ-024 sd_mosi SHALL be 1 in IDLE (SD idle-high convention).
REQ-025 cs_wr SHALL update sd_cs_n on the next cycle in any state, including mid-transfer, without disturbing the shift.
REQ-026 cs_wr and start in the same cycle SHALL both take effect.
REQ-027 rx_data SHALL hold its value between transfers.

Reset
REQ-028 While reset_n=0 at a clock edge, the block SHALL force: state IDLE, sd_sck=0, sd_mosi=1, sd_cs_n=1, busy=0, done=0, rx_data=8'h00, sd_act=0, counters 0.
REQ-029 Reset mid-transfer SHALL abort immediately: no done pulse, rx_data=8'h00.

Configuration
REQ-030 With macro SD_SPI_ACT_EN defined, sd_act SHALL be 1 while a 20-bit timeout counter is below 1,000,000. The counter SHALL be cleared whenever sd_mosi or sd_miso differs from its value in the previous cycle, and SHALL saturate at 1,000,000.
REQ-031 Without SD_SPI_ACT_EN, sd_act SHALL be tied to 0 and no timeout counter SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-032 Test: CLK_DIV=2, cs_val=0, tx_data=8'hA5 with sd_miso looped to sd_mosi -> 8 SCK pulses, each high for 2 cycles; done at cycle 33 after start; rx_data=8'hA5.
REQ-033 Test: tx_data=8'h00 with sd_miso held 1 -> sd_mosi low throughout the transfer, rx_data=8'hFF. Repeat with sd_miso held 0 -> rx_data=8'h00.
REQ-034 Test: a second start with tx_data=8'h3C pulsed at cycle 10 of a transfer -> ignored, exactly one done, rx_data from the first byte.
REQ-035 Test: reset_n=0 at cycle 12 of a transfer -> next cycle sd_sck=0, sd_cs_n=1, busy=0, rx_data=8'h00, and no done pulse.
REQ-036 Test: cs_wr with cs_val=1 at cycle 8 of a transfer -> sd_cs_n=1 from cycle 9, and the transfer completes normally.
REQ-037 Test (SD_SPI_ACT_EN): one transfer -> sd_act=1 during the transfer and for 1,000,000 cycles after the last line toggle, then 0. Without the macro -> sd_act=0 throughout.
